alu_ctrl_seq: RTL and testbench

//  Registered, parametrised ALU control decoder. Extends the RV32I decode to the full ALU op set (SLT/SLTU/SRA/branch compares).

---
 rtl/alu_ctrl_pkg.sv | 29 ++
 rtl/alu_ctrl_dec.sv | 60 ++++++
 rtl/alu_ctrl_seq.sv | 128 ++++++++++++
 tb/tb_alu_ctrl_seq.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - ALUop selectors, 4-bit ALU control codes and sequencer state type
package alu_ctrl_pkg;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_ALU = 2'b10;

    localparam logic [3:0] ALU_ADD    = 4'b0000;
    localparam logic [3:0] ALU_SLL    = 4'b0001;
    localparam logic [3:0] ALU_SLT    = 4'b0010;
    localparam logic [3:0] ALU_SLTU   = 4'b0011;
    localparam logic [3:0] ALU_XOR    = 4'b0100;
    localparam logic [3:0] ALU_SRL    = 4'b0101;
    localparam logic [3:0] ALU_OR     = 4'b0110;
    localparam logic [3:0] ALU_AND    = 4'b0111;
    localparam logic [3:0] ALU_SUB    = 4'b1000;
    localparam logic [3:0] ALU_SRA    = 4'b1101;
    localparam logic [3:0] ALU_MULDIV = 4'b1111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MEXT = 7'b0000001;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

endpackage

// File: rtl/alu_ctrl_dec.sv
// rtl/alu_ctrl_dec.sv - combinational ALU control decode; M ops recognised only with ALU_CTRL_M_EXT_EN
module alu_ctrl_dec (
    input  logic [1:0] ALUop,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       op5,
    output logic [3:0] code,
    output logic       illegal,
    output logic       is_m
);
    import alu_ctrl_pkg::*;

    always_comb begin
        code    = ALU_ADD;
        illegal = 1'b0;
        is_m    = 1'b0;
        case (ALUop)
            ALUOP_ADD: code = ALU_ADD;
            ALUOP_BR: begin
                case (funct3)
                    3'b000, 3'b001: code = ALU_SUB;
                    3'b100, 3'b101: code = ALU_SLT;
                    3'b110, 3'b111: code = ALU_SLTU;
                    default:        illegal = 1'b1;
                endcase
            end
            ALUOP_ALU: begin
                if (funct7 == F7_BASE) begin
                    code = {1'b0, funct3};
                end else if (funct7 == F7_ALT) begin
                    if (funct3 == 3'b000)
                        code = op5 ? ALU_SUB : ALU_ADD;
                    else if (funct3 == 3'b101)
                        code = ALU_SRA;
                    else
                        illegal = 1'b1;
                end else if (op5) begin
                    if (funct7 == F7_MEXT) begin
                        code = ALU_MULDIV;
`ifdef ALU_CTRL_M_EXT_EN
                        is_m = 1'b1;
`else
                        illegal = 1'b1;
`endif
                    end else begin
                        illegal = 1'b1;
                    end
                end else begin
                    // I-type immediates carry no funct7; only the shifts need it
                    if (funct3 == 3'b001 || funct3 == 3'b101)
                        illegal = 1'b1;
                    else
                        code = {1'b0, funct3};
                end
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_ctrl_seq.sv
// rtl/alu_ctrl_seq.sv - registered ALU control decoder with mul/div sequencer under ALU_CTRL_M_EXT_EN
module alu_ctrl_seq #(
    parameter int CTRL_W  = 4,
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_i,
    input  logic [1:0]        ALUop,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic              op5,
    input  logic              flush_i,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic              ctrl_valid,
    output logic              illegal,
    output logic              muldiv_start,
    output logic [2:0]        muldiv_op,
    output logic              stall
);
    import alu_ctrl_pkg::*;

    logic [3:0] dec_code;
    logic       dec_illegal;
    logic       dec_is_m;

    alu_ctrl_dec u_dec (
        .ALUop   (ALUop),
        .funct3  (funct3),
        .funct7  (funct7),
        .op5     (op5),
        .code    (dec_code),
        .illegal (dec_illegal),
        .is_m    (dec_is_m)
    );

`ifdef ALU_CTRL_M_EXT_EN
    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    state_t         state;
    logic [CNT_W-1:0] cnt;
    logic           start_q;
    logic [2:0]     op_q;
    logic           stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            ctrl_valid <= 1'b0;
            alu_ctrl   <= '0;
            illegal    <= 1'b0;
            start_q    <= 1'b0;
            op_q       <= 3'b000;
            stall_q    <= 1'b0;
        end else if (flush_i) begin
            state      <= IDLE;
            cnt        <= '0;
            ctrl_valid <= 1'b0;
            start_q    <= 1'b0;
            stall_q    <= 1'b0;
        end else begin
            ctrl_valid <= 1'b0;
            start_q    <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid_i) begin
                        if (dec_is_m) begin
                            start_q <= 1'b1;
                            op_q    <= funct3;
                            stall_q <= 1'b1;
                            state   <= BUSY;
                            cnt     <= funct3[2] ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
                        end else begin
                            ctrl_valid <= 1'b1;
                            alu_ctrl   <= CTRL_W'(dec_code);
                            illegal    <= dec_illegal;
                        end
                    end
                end
                BUSY: begin
                    // requests arriving while busy are dropped, upstream sees stall
                    if (cnt == '0) begin
                        ctrl_valid <= 1'b1;
                        alu_ctrl   <= CTRL_W'(ALU_MULDIV);
                        illegal    <= 1'b0;
                        stall_q    <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
            endcase
        end
    end

    assign muldiv_start = start_q;
    assign muldiv_op    = op_q;
    assign stall        = stall_q;
`else
    localparam int unused_lat = MUL_LAT + DIV_LAT;
    logic unused_is_m;
    assign unused_is_m = dec_is_m;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_valid <= 1'b0;
            alu_ctrl   <= '0;
            illegal    <= 1'b0;
        end else if (flush_i) begin
            ctrl_valid <= 1'b0;
        end else begin
            ctrl_valid <= valid_i;
            if (valid_i) begin
                alu_ctrl <= CTRL_W'(dec_code);
                illegal  <= dec_illegal;
            end
        end
    end

    assign muldiv_start = 1'b0;
    assign muldiv_op    = 3'b000;
    assign stall        = 1'b0;
`endif

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb/tb_alu_ctrl_seq.sv - scoreboard bench for alu_ctrl_seq, model follows ALU_CTRL_M_EXT_EN
module tb_alu_ctrl_seq;

    localparam int CW      = 5;
    localparam int MUL_LAT = 3;
    localparam int DIV_LAT = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          valid_i;
    logic [1:0]    ALUop;
    logic [2:0]    funct3;
    logic [6:0]    funct7;
    logic          op5;
    logic          flush_i;
    logic [CW-1:0] alu_ctrl;
    logic          ctrl_valid;
    logic          illegal;
    logic          muldiv_start;
    logic [2:0]    muldiv_op;
    logic          stall;

    alu_ctrl_seq #(.CTRL_W(CW), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid_i      (valid_i),
        .ALUop        (ALUop),
        .funct3       (funct3),
        .funct7       (funct7),
        .op5          (op5),
        .flush_i      (flush_i),
        .alu_ctrl     (alu_ctrl),
        .ctrl_valid   (ctrl_valid),
        .illegal      (illegal),
        .muldiv_start (muldiv_start),
        .muldiv_op    (muldiv_op),
        .stall        (stall)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [3:0] code;
        bit         ill;
    } exp_t;

    typedef struct {
        int         cyc;
        logic [2:0] op;
    } start_t;

    exp_t   cq[$];
    start_t sq[$];
    int     m_start = -1;
    int     m_end   = -1;
    logic [3:0] last_code = 4'b0000;
    bit     last_ill = 1'b0;
    bit     run = 1'b0;
    int     n_pass = 0;
    int     n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    endtask

    // Decode rules straight from the opcode table
    function automatic void ref_decode(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                       input bit o5, output logic [3:0] code, output bit ill, output bit m);
        code = 4'b0000;
        ill  = 1'b0;
        m    = 1'b0;
        if (op == 2'd0) begin
            code = 4'b0000;
        end else if (op == 2'd1) begin
            if (f3 == 3'd2 || f3 == 3'd3) ill = 1'b1;
            else if (f3 < 3'd2) code = 4'b1000;
            else if (f3 < 3'd6) code = 4'b0010;
            else code = 4'b0011;
        end else if (op == 2'd3) begin
            ill = 1'b1;
        end else if (f7 == 7'h00) begin
            code = {1'b0, f3};
        end else if (f7 == 7'h20) begin
            if (f3 == 3'd0) code = o5 ? 4'b1000 : 4'b0000;
            else if (f3 == 3'd5) code = 4'b1101;
            else ill = 1'b1;
        end else if (o5) begin
            if (f7 == 7'h01) begin
`ifdef ALU_CTRL_M_EXT_EN
                m = 1'b1;
`else
                ill = 1'b1;
`endif
            end else begin
                ill = 1'b1;
            end
        end else begin
            if (f3 == 3'd1 || f3 == 3'd5) ill = 1'b1;
            else code = {1'b0, f3};
        end
    endfunction

    task automatic model_edge(input int e, input bit v, input logic [1:0] op, input logic [2:0] f3,
                              input logic [6:0] f7, input bit o5, input bit fl);
        logic [3:0] code;
        bit ill, m, busy;
        exp_t ce;
        start_t se;
        busy = (e > m_start) && (e <= m_end);
        if (fl) begin
            if (busy) begin
                m_end = e;
                while (cq.size() > 0 && cq[cq.size()-1].cyc >= e) void'(cq.pop_back());
            end
        end else if (!busy && v) begin
            ref_decode(op, f3, f7, o5, code, ill, m);
            if (m) begin
                se.cyc = e; se.op = f3;
                sq.push_back(se);
                m_start = e;
                m_end   = e + (f3[2] ? DIV_LAT : MUL_LAT);
                ce.cyc = m_end; ce.code = 4'b1111; ce.ill = 1'b0;
                cq.push_back(ce);
            end else begin
                ce.cyc = e; ce.code = code; ce.ill = ill;
                cq.push_back(ce);
            end
        end
    endtask

    task automatic step(input bit v, input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input bit o5, input bit fl);
        valid_i = v; ALUop = op; funct3 = f3; funct7 = f7; op5 = o5; flush_i = fl;
        model_edge(cyc + 1, v, op, f3, f7, o5, fl);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'b00, 3'b000, 7'h00, 1'b0, 1'b0);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_alu_ctrl"}, alu_ctrl, 0);
        chk({tag, "_ctrl_valid"}, ctrl_valid, 0);
        chk({tag, "_illegal"}, illegal, 0);
        chk({tag, "_muldiv_start"}, muldiv_start, 0);
        chk({tag, "_muldiv_op"}, muldiv_op, 0);
        chk({tag, "_stall"}, stall, 0);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && run) begin
            chk("stall", stall, (cyc >= m_start && cyc < m_end) ? 1 : 0);
            if (sq.size() > 0 && sq[0].cyc == cyc) begin
                chk("muldiv_start", muldiv_start, 1);
                chk("muldiv_op", muldiv_op, sq[0].op);
                void'(sq.pop_front());
            end else begin
                chk("muldiv_start_quiet", muldiv_start, 0);
            end
            if (cq.size() > 0 && cq[0].cyc == cyc) begin
                chk("ctrl_valid", ctrl_valid, 1);
                chk("illegal", illegal, cq[0].ill);
                if (!cq[0].ill) chk("alu_ctrl", alu_ctrl, cq[0].code);
                last_code = cq[0].code;
                last_ill  = cq[0].ill;
                void'(cq.pop_front());
            end else begin
                chk("ctrl_valid_quiet", ctrl_valid, 0);
                chk("illegal_hold", illegal, last_ill);
                if (!last_ill) chk("alu_ctrl_hold", alu_ctrl, last_code);
            end
        end
    end

    logic [6:0] f7_pick [5];

    initial begin
        rst_n = 1'b0;
        valid_i = 1'b0; ALUop = 2'b00; funct3 = 3'b000; funct7 = 7'h00; op5 = 1'b0; flush_i = 1'b0;
        f7_pick[0] = 7'h00; f7_pick[1] = 7'h20; f7_pick[2] = 7'h01; f7_pick[3] = 7'h02; f7_pick[4] = 7'h55;
        repeat (3) @(posedge clk);
        #1;
        chk_zero_outputs("reset");
        rst_n = 1'b1;
        run = 1'b1;

        step(1, 2'b10, 3'b000, 7'h20, 1, 0);
        step(1, 2'b10, 3'b000, 7'h20, 0, 0);
        idle(1);
        step(1, 2'b01, 3'b000, 7'h00, 0, 0);
        step(1, 2'b01, 3'b101, 7'h00, 0, 0);
        step(1, 2'b01, 3'b111, 7'h00, 0, 0);
        idle(1);
        step(1, 2'b10, 3'b000, 7'h01, 1, 0);
        idle(5);
        step(1, 2'b10, 3'b100, 7'h01, 1, 0);
        repeat (4) step(1, 2'b10, 3'b100, 7'h01, 1, 0);
        step(1, 2'b10, 3'b000, 7'h00, 1, 1);
        idle(3);
        step(1, 2'b11, 3'b000, 7'h00, 0, 0);
        step(1, 2'b10, 3'b000, 7'h02, 1, 0);
        step(1, 2'b10, 3'b101, 7'h20, 1, 0);
        step(1, 2'b10, 3'b101, 7'h33, 0, 0);
        step(1, 2'b10, 3'b110, 7'h33, 0, 0);
        idle(2);

        step(1, 2'b10, 3'b100, 7'h01, 1, 0);
        idle(21);
        valid_i = 1'b0; flush_i = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("reset_busy");
        cq.delete(); sq.delete();
        m_start = -1; m_end = -1; last_code = 4'b0000; last_ill = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1, 2'b00, 3'b011, 7'h00, 0, 0);
        idle(2);

        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 9) < 8) ? 2'b10 : 2'($urandom_range(0, 3)),
                 3'($urandom_range(0, 7)),
                 f7_pick[$urandom_range(0, 4)],
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 39) == 0));
        end
        idle(40);
        chk("ctrl_queue_drained", cq.size(), 0);
        chk("start_queue_drained", sq.size(), 0);
        run = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
